dcdc_bias_seq: RTL and testbench

Power-rail sequencer that sits directly downstream of the DC-DC clock generator. It consumes the generator's 1 MHz clock, edge-detected into a 1 µs timebase tick. It enables NUM_RAILS bias DC-DC converters in ascending order on power-up and disables them in descending order on power-down, checking each rail's power-good. It also gates the 5 MHz converter sync clock and reports ready, busy and fault status to the panel control logic.

---
 rtl/dcdc_bias_seq_pkg.sv | 30 +++
 rtl/dcdc_bias_seq_if.sv | 41 ++++
 rtl/dcdc_bias_seq_tick_gen.sv | 45 ++++
 rtl/dcdc_bias_seq.sv | 213 +++++++++++++++++++++
 tb/tb_dcdc_bias_seq.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcdc_bias_seq_pkg.sv
// ---------------------------------------------------------------------------
// dcdc_pkg
// Shared types and constants for the bias-rail power sequencer.
//   seq_state_t   : sequencer FSM states
//   PG_TIMEOUT_US : default power-good wait limit in microseconds
//   STEP_DLY_US   : default inter-rail step delay in microseconds
//   is_busy()     : true for every transient sequencing state
// ---------------------------------------------------------------------------
package dcdc_pkg;

    typedef enum logic [2:0] {
        OFF,
        UP_EN,
        UP_PG,
        UP_DLY,
        ON,
        DN,
        DN_DLY,
        FAULT
    } seq_state_t;

    localparam int PG_TIMEOUT_US = 1000;
    localparam int STEP_DLY_US   = 5;

    // Steady states (OFF, ON, FAULT) are the only non-busy ones.
    function automatic logic is_busy(input seq_state_t s);
        return !((s == OFF) || (s == ON) || (s == FAULT));
    endfunction

endpackage

// File: rtl/dcdc_bias_seq_if.sv
// ---------------------------------------------------------------------------
// dcdc_bias_seq_if
// Control/status bundle between the panel control logic (master) and the
// bias-rail sequencer (slave).
//   en_i         : rail on/off level request
//   clr_fault_i  : single-cycle fault clear pulse
//   step_dly_i   : per-step delay in microseconds
//   pg_i         : asynchronous per-rail power-good
//   rail_en_o    : registered converter enables
//   ready_o      : all rails up and good
//   busy_o       : sequencing in progress
//   fault_o      : sticky fault flag
//   fault_rail_o : index of the rail that caused the fault
// ---------------------------------------------------------------------------
interface dcdc_bias_seq_if #(
    parameter int NUM_RAILS = 4,
    parameter int DLY_W     = 16
);
    localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

    logic                 en_i;
    logic                 clr_fault_i;
    logic [DLY_W-1:0]     step_dly_i;
    logic [NUM_RAILS-1:0] pg_i;
    logic [NUM_RAILS-1:0] rail_en_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 fault_o;
    logic [IDX_W-1:0]     fault_rail_o;

    modport master (
        output en_i, clr_fault_i, step_dly_i, pg_i,
        input  rail_en_o, ready_o, busy_o, fault_o, fault_rail_o
    );

    modport slave (
        input  en_i, clr_fault_i, step_dly_i, pg_i,
        output rail_en_o, ready_o, busy_o, fault_o, fault_rail_o
    );

endinterface

// File: rtl/dcdc_bias_seq_tick_gen.sv
// ---------------------------------------------------------------------------
// dcdc_tick_gen
// Turns the 1 MHz generator clock into a 1 us tick and counts ticks.
//   clk      : system clock (same domain as clk_1M_i)
//   reset_n  : asynchronous active-low reset
//   clk_1M_i : 1 MHz clock, sampled in clk
//   clr      : synchronous counter clear (wins over a coincident tick)
//   us_cnt   : saturating microsecond count since the last clear
// ---------------------------------------------------------------------------
module dcdc_tick_gen #(
    parameter int DLY_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_1M_i,
    input  logic             clr,
    output logic [DLY_W-1:0] us_cnt
);

    logic clk_1M_q;
    logic tick;

    // Rising edge of clk_1M_i: previous sample low, current sample high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_1M_q <= 1'b0;
        end else begin
            clk_1M_q <= clk_1M_i;
        end
    end

    assign tick = clk_1M_i & ~clk_1M_q;

    // Counter holds at all-ones so a long wait can never look like a short one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            us_cnt <= '0;
        end else if (clr) begin
            us_cnt <= '0;
        end else if (tick && (us_cnt != '1)) begin
            us_cnt <= us_cnt + DLY_W'(1);
        end
    end

endmodule

// File: rtl/dcdc_bias_seq.sv
// ---------------------------------------------------------------------------
// dcdc_bias_seq
// Bias-rail power sequencer. Brings NUM_RAILS converters up in ascending
// order and down in descending order, checking power-good per rail, and
// gates the 5 MHz converter sync clock while the rails are in use.
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   clk_1M_i    : 1 MHz timebase clock
//   clk_5M_i    : 5 MHz converter sync clock
//   dcdc_sync_o : clk_5M_i gated by a registered enable
//   bus         : control/status bundle (slave side)
// ---------------------------------------------------------------------------
module dcdc_bias_seq
    import dcdc_pkg::*;
#(
    parameter int NUM_RAILS   = 4,
    parameter int DLY_W       = 16,
    parameter int PG_TIMEOUT  = PG_TIMEOUT_US,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clk_1M_i,
    input  logic           clk_5M_i,
    output logic           dcdc_sync_o,
    dcdc_bias_seq_if.slave bus
);

    localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);
    localparam logic [DLY_W-1:0] PG_LIMIT = DLY_W'(PG_TIMEOUT);

    seq_state_t           state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [NUM_RAILS-1:0] rail_en, rail_en_next;
    logic [IDX_W-1:0]     fault_rail, fault_rail_next;
    logic [DLY_W-1:0]     dly_q, dly_next;
    logic                 gate_req, gate_next;
    logic                 sync_gate;
    logic [DLY_W-1:0]     us_cnt;
    logic                 cnt_clr;
    logic [NUM_RAILS-1:0] pg_sync_q [SYNC_STAGES];
    logic [NUM_RAILS-1:0] pg_sync;
    logic [NUM_RAILS-1:0] pg_lost;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_RAILS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Multi-flop synchronizer chain on every asynchronous power-good bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) pg_sync_q[s] <= '0;
        end else begin
            pg_sync_q[0] <= bus.pg_i;
            for (int s = 1; s < SYNC_STAGES; s++) pg_sync_q[s] <= pg_sync_q[s-1];
        end
    end

    assign pg_sync = pg_sync_q[SYNC_STAGES-1];
    assign pg_lost = rail_en & ~pg_sync;

    // Microsecond counter restarts whenever the FSM changes state.
    assign cnt_clr = (state_next != state);

    dcdc_tick_gen #(.DLY_W(DLY_W)) u_tick_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_1M_i (clk_1M_i),
        .clr      (cnt_clr),
        .us_cnt   (us_cnt)
    );

    // State and datapath registers; all rails drop at once on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= OFF;
            idx        <= '0;
            rail_en    <= '0;
            fault_rail <= '0;
            dly_q      <= '0;
            gate_req   <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            rail_en    <= rail_en_next;
            fault_rail <= fault_rail_next;
            dly_q      <= dly_next;
            gate_req   <= gate_next;
        end
    end

    // Next-state logic. Within one cycle a fault beats an en_i change,
    // which beats the normal advance.
    always_comb begin
        state_next      = state;
        idx_next        = idx;
        rail_en_next    = rail_en;
        fault_rail_next = fault_rail;
        dly_next        = dly_q;
        gate_next       = gate_req;

        unique case (state)
            OFF: begin
                if (bus.en_i) begin
                    state_next = UP_EN;
                    idx_next   = '0;
                    gate_next  = 1'b1;
                end
            end
            UP_EN: begin
                if (!bus.en_i) begin
                    state_next = DN;
                end else begin
                    rail_en_next[idx] = 1'b1;
                    state_next        = UP_PG;
                end
            end
            UP_PG: begin
                if (!pg_sync[idx] && (us_cnt >= PG_LIMIT)) begin
                    state_next      = FAULT;
                    fault_rail_next = idx;
                end else if (!bus.en_i) begin
                    state_next = DN;
                end else if (pg_sync[idx]) begin
                    state_next = UP_DLY;
                end
            end
            UP_DLY: begin
                if (!bus.en_i) begin
                    state_next = DN;
                end else if (us_cnt == dly_q) begin
                    if (idx == LAST_IDX) begin
                        state_next = ON;
                    end else begin
                        idx_next   = idx + IDX_W'(1);
                        state_next = UP_EN;
                    end
                end
            end
            ON: begin
                if (|pg_lost) begin
                    state_next      = FAULT;
                    fault_rail_next = lowest_set(pg_lost);
                end else if (!bus.en_i) begin
                    state_next = DN;
                    idx_next   = LAST_IDX;
                end
            end
            DN: begin
                rail_en_next[idx] = 1'b0;
                state_next        = DN_DLY;
            end
            DN_DLY: begin
                if (us_cnt == dly_q) begin
                    if (idx == '0) begin
                        state_next = OFF;
                        gate_next  = 1'b0;
                    end else begin
                        idx_next   = idx - IDX_W'(1);
                        state_next = DN;
                    end
                end
            end
            FAULT: begin
                // Returning to OFF also forgets which rail tripped.
                if (bus.clr_fault_i && !bus.en_i) begin
                    state_next      = OFF;
                    idx_next        = '0;
                    fault_rail_next = '0;
                end
            end
            default: begin
                state_next = OFF;
            end
        endcase

        // Delay is captured as a state is entered so later changes on
        // step_dly_i cannot stretch or cut a step already in progress.
        if ((state_next != state) && ((state_next == UP_DLY) || (state_next == DN_DLY))) begin
            dly_next = bus.step_dly_i;
        end

        // Entering FAULT kills every rail and the sync clock together.
        if ((state_next == FAULT) && (state != FAULT)) begin
            rail_en_next = '0;
            gate_next    = 1'b0;
        end
    end

    // The output gate only follows the request while clk_5M_i is low,
    // so the AND below never produces a runt pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_gate <= 1'b0;
        end else if (!clk_5M_i) begin
            sync_gate <= gate_req;
        end
    end

    assign dcdc_sync_o      = clk_5M_i & sync_gate;
    assign bus.rail_en_o    = rail_en;
    assign bus.ready_o      = (state == ON);
    assign bus.busy_o       = is_busy(state);
    assign bus.fault_o      = (state == FAULT);
    assign bus.fault_rail_o = fault_rail;

endmodule

// File: tb/tb_dcdc_bias_seq.sv
// ---------------------------------------------------------------------------
// tb_dcdc_bias_seq
// Scoreboard bench for dcdc_bias_seq. Stimulus queues the expected status
// words; a monitor compares each distinct status change against the queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dcdc_bias_seq;

    localparam int NUM_RAILS    = 4;
    localparam int DLY_W        = 16;
    localparam int PG_DELAY_CYC = 60;

    typedef struct packed {
        logic [3:0] rail_en;
        logic       ready;
        logic       busy;
        logic       fault;
        logic [1:0] fault_rail;
    } status_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clk_1M  = 1'b0;
    logic clk_5M  = 1'b0;
    logic dcdc_sync;

    logic [3:0] pg_model = '0;
    logic [3:0] pg_block = '0;
    logic [3:0] pg_kill  = '0;
    logic       pg_tie   = 1'b0;
    int         pg_cnt [NUM_RAILS];

    int      errors = 0;
    int      checks = 0;
    bit      mon_en = 1'b0;
    status_t exp_q [$];

    dcdc_bias_seq_if #(.NUM_RAILS(NUM_RAILS), .DLY_W(DLY_W)) bus ();

    dcdc_bias_seq #(
        .NUM_RAILS   (NUM_RAILS),
        .DLY_W       (DLY_W),
        .PG_TIMEOUT  (1000),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_1M_i    (clk_1M),
        .clk_5M_i    (clk_5M),
        .dcdc_sync_o (dcdc_sync),
        .bus         (bus)
    );

    // 20 MHz system clock; 1 MHz and 5 MHz clocks offset so their edges
    // never coincide with a system clock edge.
    always #25 clk = ~clk;
    initial begin
        #10;
        forever #500 clk_1M = ~clk_1M;
    end
    initial begin
        #10;
        forever #100 clk_5M = ~clk_5M;
    end

    assign bus.pg_i = (pg_model | {NUM_RAILS{pg_tie}}) & ~pg_kill;

    // Converter model: power-good follows its enable after 3 us unless blocked.
    always @(negedge clk) begin
        for (int r = 0; r < NUM_RAILS; r++) begin
            if (!bus.rail_en_o[r]) begin
                pg_cnt[r]   = 0;
                pg_model[r] = 1'b0;
            end else if (pg_cnt[r] < PG_DELAY_CYC) begin
                pg_cnt[r]++;
            end else if (!pg_block[r]) begin
                pg_model[r] = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic clr, input logic [DLY_W-1:0] dly);
        @(negedge clk);
        bus.en_i        = en;
        bus.clr_fault_i = clr;
        bus.step_dly_i  = dly;
        if (clr) begin
            @(negedge clk);
            bus.clr_fault_i = 1'b0;
        end
    endtask

    task automatic expect_status(input logic [3:0] re, input logic rdy, input logic bsy,
                                 input logic flt, input logic [1:0] fr);
        status_t s;
        s.rail_en    = re;
        s.ready      = rdy;
        s.busy       = bsy;
        s.fault      = flt;
        s.fault_rail = fr;
        exp_q.push_back(s);
    endtask

    task automatic expect_power_up();
        expect_status(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0111, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic expect_power_down();
        expect_status(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0111, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic count_sync_highs(input int cyc, output int n);
        n = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (dcdc_sync) n++;
        end
    endtask

    function automatic status_t sample_status();
        status_t s;
        s.rail_en    = bus.rail_en_o;
        s.ready      = bus.ready_o;
        s.busy       = bus.busy_o;
        s.fault      = bus.fault_o;
        s.fault_rail = bus.fault_rail_o;
        return s;
    endfunction

    // Monitor: every change of the status word is one DUT output event.
    initial begin
        status_t cur, prev, exp;
        bit first;
        int ev;
        first = 1'b1;
        ev    = 0;
        prev  = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            cur = sample_status();
            if (first || (cur != prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_change%0d: actual=0x%0h required=0x%0h",
                             ev, cur, prev);
                end else begin
                    exp = exp_q.pop_front();
                    checkOutput($sformatf("event%0d", ev), 32'(cur), 32'(exp));
                end
                ev++;
                first = 1'b0;
            end
            prev = cur;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bus.en_i        = 1'b0;
        bus.clr_fault_i = 1'b0;
        bus.step_dly_i  = 16'd5;

        $display("[TB] reset");
        expect_status(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_sync", 32'(dcdc_sync), 32'd0);
        reset_n = 1'b1;
        drain(10, "reset");

        $display("[TB] power-up, step 5 us");
        expect_power_up();
        applyStimulus(1'b1, 1'b0, 16'd5);
        drain(5000, "powerup");
        count_sync_highs(40, n);
        checkOutput("sync_running", 32'(n > 0), 32'd1);

        $display("[TB] power-down");
        expect_power_down();
        applyStimulus(1'b0, 1'b0, 16'd5);
        drain(5000, "powerdown");
        repeat (10) @(negedge clk);
        count_sync_highs(40, n);
        checkOutput("sync_stopped", 32'(n), 32'd0);

        $display("[TB] pg timeout on rail 2");
        pg_block = 4'b0100;
        expect_status(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0111, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0000, 1'b0, 1'b0, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b0, 16'd5);
        drain(25000, "timeout");
        checkOutput("timeout_rail", 32'(bus.fault_rail_o), 32'd2);
        applyStimulus(1'b1, 1'b1, 16'd5);
        count_sync_highs(40, n);
        checkOutput("clr_ignored", 32'(bus.fault_o), 32'd1);
        checkOutput("fault_sync_off", 32'(n), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'd5);
        repeat (5) @(negedge clk);
        expect_status(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 16'd5);
        drain(100, "fault_clear");
        pg_block = 4'b0000;

        $display("[TB] pg loss in ON");
        expect_power_up();
        applyStimulus(1'b1, 1'b0, 16'd5);
        drain(5000, "pgloss_up");
        expect_status(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        pg_kill = 4'b0010;
        n = 0;
        while (!bus.fault_o && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pgloss_latency", 32'((n >= 2) && (n <= 4)), 32'd1);
        drain(10, "pgloss");
        pg_kill = 4'b0000;
        expect_status(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 16'd5);
        drain(100, "pgloss_clear");

        $display("[TB] abort during rail 2 power-good wait");
        expect_status(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0111, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_status(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 16'd5);
        n = 0;
        while (!bus.rail_en_o[2] && (n < 5000)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_rail2_up", 32'(bus.rail_en_o[2]), 32'd1);
        repeat (10) @(negedge clk);
        bus.en_i = 1'b0;
        drain(5000, "abort");
        checkOutput("abort_no_fault", 32'(bus.fault_o), 32'd0);

        $display("[TB] zero-delay run with pg tied high");
        pg_tie = 1'b1;
        repeat (5) @(negedge clk);
        expect_power_up();
        applyStimulus(1'b1, 1'b0, 16'd0);
        n = 0;
        while (!bus.rail_en_o[0] && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rail0_latency", 32'(n), 32'd2);
        while (!bus.ready_o && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("zero_dly_fast", 32'(n <= 16), 32'd1);
        drain(50, "zero_up");
        expect_power_down();
        applyStimulus(1'b0, 1'b0, 16'd0);
        drain(200, "zero_down");
        pg_tie = 1'b0;

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
